// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared FSM encoding, default timing parameters and length helper
package spi_arb_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_CS_SETUP = 2;
   localparam int DEF_CS_HOLD  = 2;
   localparam int MAX_LEN      = 32;
   // Zero or oversized lengths fall back to a full word
   function automatic logic [5:0] eff_len(logic [5:0] len);
      return (len == 6'd0 || len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : len;
   endfunction
endpackage

// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: requester handshake and SPI pin bundle
interface spi_bus_arbiter_if;
   logic [1:0]  req;
   logic [1:0]  sel;
   logic [11:0] len;
   logic [63:0] wdata;
   logic [1:0]  gnt;
   logic [1:0]  done;
   logic [31:0] rdata;
   logic        spi_clk;
   logic        spi_mosi;
   logic        spi_miso;
   logic        spi_cs0;
   logic        spi_cs1;
   modport master (output req, sel, len, wdata, spi_miso,
                   input gnt, done, rdata, spi_clk, spi_mosi, spi_cs0, spi_cs1);
   modport slave  (input req, sel, len, wdata, spi_miso,
                   output gnt, done, rdata, spi_clk, spi_mosi, spi_cs0, spi_cs1);
endinterface

// File: rtl/spi_rr_arbiter2.sv
// spi_rr_arbiter2: two-way round-robin grant with last-grant pointer
module spi_rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] winner
);
   logic last;
   always_comb winner = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last <= 1'b1;
      else if (advance) last <= winner[1];
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: two-requester SPI master, mode 0, MSB first, round-robin shared bus
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int CS_SETUP = DEF_CS_SETUP,
   parameter int CS_HOLD  = DEF_CS_HOLD
) (
   input logic SCLK,
   input logic SRESETn,
   spi_bus_arbiter_if.slave bus
);
   state_t      state;
   logic [7:0]  cnt;
   logic [5:0]  bits;
   logic [31:0] tx, rx, rdata_q;
   logic [1:0]  gnt_q, done_q, win;
   logic        owner, clk_q, mosi_q, cs0_q, cs1_q;
   logic        start, w_own, w_sel, phase_end;
   logic [5:0]  w_len, eff;
   logic [31:0] w_data, tx_n;
   assign start     = state == IDLE && |bus.req;
   assign w_own     = win[1];
   assign w_sel     = bus.sel[w_own];
   assign w_len     = w_own ? bus.len[11:6] : bus.len[5:0];
   assign w_data    = w_own ? bus.wdata[63:32] : bus.wdata[31:0];
   assign eff       = eff_len(w_len);
   // Left-align the word so the MSB to send always sits in tx[31]
   assign tx_n      = w_data << (6'(MAX_LEN) - eff);
   assign phase_end = cnt == 8'(CLK_DIV - 1);
   spi_rr_arbiter2 u_arb (
      .clk     (SCLK),
      .rst_n   (SRESETn),
      .req     (bus.req),
      .advance (start),
      .winner  (win)
   );
   always_ff @(posedge SCLK or negedge SRESETn)
      if (!SRESETn) begin
         state   <= IDLE;
         cnt     <= '0;
         bits    <= '0;
         tx      <= '0;
         rx      <= '0;
         rdata_q <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         owner   <= 1'b0;
         clk_q   <= 1'b0;
         mosi_q  <= 1'b0;
         cs0_q   <= 1'b1;
         cs1_q   <= 1'b1;
      end else begin
         gnt_q  <= '0;
         done_q <= '0;
         cnt    <= cnt + 8'd1;
         unique case (state)
            IDLE: if (start) begin
               state  <= SETUP;
               cnt    <= '0;
               gnt_q  <= win;
               owner  <= w_own;
               cs0_q  <= w_sel;
               cs1_q  <= !w_sel;
               bits   <= eff;
               tx     <= tx_n;
               rx     <= '0;
               mosi_q <= tx_n[31];
            end
            SETUP: if (cnt == 8'(CS_SETUP - 1)) begin
               state <= SHIFT;
               cnt   <= '0;
            end
            // Low phase ends with a rise (sample MISO); high phase ends with a fall (advance MOSI)
            SHIFT: if (phase_end) begin
               cnt   <= '0;
               clk_q <= !clk_q;
               if (!clk_q) rx <= {rx[30:0], bus.spi_miso};
               else if (bits == 6'd1) state <= HOLD;
               else begin
                  bits   <= bits - 6'd1;
                  tx     <= tx << 1;
                  mosi_q <= tx[30];
               end
            end
            HOLD: if (cnt == 8'(CS_HOLD - 1)) begin
               state   <= IDLE;
               cs0_q   <= 1'b1;
               cs1_q   <= 1'b1;
               mosi_q  <= 1'b0;
               done_q  <= owner ? 2'b10 : 2'b01;
               rdata_q <= rx;
            end
         endcase
      end
   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.rdata    = rdata_q;
   assign bus.spi_clk  = clk_q;
   assign bus.spi_mosi = mosi_q;
   assign bus.spi_cs0  = cs0_q;
   assign bus.spi_cs1  = cs1_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: scoreboard bench with echoing SPI slave and a fast-timing second instance
module tb_spi_bus_arbiter;
   localparam logic [31:0] ECHO0 = 32'h3C00_0000;
   localparam logic [31:0] ECHO1 = 32'hC3A5_5A0F;
   typedef struct {
      logic [1:0]  done;
      logic [31:0] rdata;
      int          rises;
      logic [31:0] mosi;
      int          cs0;
      int          cs1;
   } exp_t;
   logic SCLK = 1'b0;
   logic SRESETn = 1'b1;
   int checks = 0, errors = 0;
   exp_t sbq[$];
   exp_t mon_x;
   int c0 = 0, c1 = 0;
   logic [31:0] s_tx = '0, s_rx = '0;
   int s_rises = 0;
   logic cs_act, cs_prev = 1'b0, clk_prev = 1'b0;
   always #5 SCLK = ~SCLK;
   spi_bus_arbiter_if bus ();
   spi_bus_arbiter_if bus2 ();
   spi_bus_arbiter dut (.SCLK(SCLK), .SRESETn(SRESETn), .bus(bus));
   spi_bus_arbiter #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut2 (.SCLK(SCLK), .SRESETn(SRESETn), .bus(bus2));
   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask
   // Mode-0 slave: shifts ECHO out MSB first from CS fall, captures MOSI on rises
   assign cs_act = !(bus.spi_cs0 && bus.spi_cs1);
   assign bus.spi_miso = s_tx[31];
   assign bus2.spi_miso = 1'b1;
   always @(cs_act or bus.spi_clk) begin
      if (cs_act && !cs_prev) begin
         s_tx = !bus.spi_cs0 ? ECHO0 : ECHO1;
         s_rx = '0;
         s_rises = 0;
      end else if (bus.spi_clk && !clk_prev) begin
         s_rx = {s_rx[30:0], bus.spi_mosi};
         s_rises++;
      end else if (!bus.spi_clk && clk_prev) s_tx = s_tx << 1;
      cs_prev = cs_act;
      clk_prev = bus.spi_clk;
   end
   always @(negedge SCLK) begin
      check("cs_overlap", 64'(bus.spi_cs0 | bus.spi_cs1), 1);
      check("cs_overlap2", 64'(bus2.spi_cs0 | bus2.spi_cs1), 1);
      if (!SRESETn) begin
         c0 = 0;
         c1 = 0;
      end else begin
         if (bus.spi_cs0 && bus.spi_cs1) check("idle_lines", {bus.spi_clk, bus.spi_mosi}, 0);
         c0 += int'(!bus.spi_cs0);
         c1 += int'(!bus.spi_cs1);
         if (|bus.done) begin
            if (sbq.size() == 0) check("done_unexpected", bus.done, 0);
            else begin
               mon_x = sbq.pop_front();
               check("done_owner", bus.done, mon_x.done);
               check("rdata", bus.rdata, mon_x.rdata);
               check("rises", s_rises, mon_x.rises);
               check("mosi_bits", s_rx, mon_x.mosi);
               check("cs_low", {c1, c0}, {mon_x.cs1, mon_x.cs0});
            end
            c0 = 0;
            c1 = 0;
         end
      end
   end
   task automatic setup(int r, int s, int l, logic [31:0] w);
      exp_t x;
      int e;
      e = (l >= 1 && l <= 32) ? l : 32;
      bus.sel[r] = s[0];
      bus.len[6*r +: 6] = 6'(l);
      bus.wdata[32*r +: 32] = w;
      x.done  = (r == 1) ? 2'b10 : 2'b01;
      x.rdata = (s != 0 ? ECHO1 : ECHO0) >> (32 - e);
      x.rises = e;
      x.mosi  = (e == 32) ? w : w & ~(32'hFFFF_FFFF << e);
      x.cs0   = (s != 0) ? 0 : 4 + 4*e;
      x.cs1   = (s != 0) ? 4 + 4*e : 0;
      sbq.push_back(x);
   endtask
   task automatic wait_gnt(int r);
      int n = 0;
      while (!bus.gnt[r] && n < 500) begin
         @(negedge SCLK);
         n++;
      end
      check("gnt_wait", 64'(n < 500), 1);
      bus.req[r] = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (sbq.size() != 0 && n < 3000) begin
         @(negedge SCLK);
         n++;
      end
      check("drain", sbq.size(), 0);
      @(negedge SCLK);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      int lens[4] = '{1, 32, 0, 40};
      int n, g, c;
      bus.req = '0; bus.sel = '0; bus.len = '0; bus.wdata = '0;
      bus2.req = '0; bus2.sel = '0; bus2.len = '0; bus2.wdata = '0;
      #1 SRESETn = 1'b0;
      repeat (3) @(negedge SCLK);
      check("rst_cs", {bus.spi_cs1, bus.spi_cs0}, 2'b11);
      check("rst_lines", {bus.spi_clk, bus.spi_mosi, bus.gnt, bus.done}, 0);
      check("rst_rdata", bus.rdata, 0);
      SRESETn = 1'b1;
      @(negedge SCLK);
      // Tie from reset: r0 first, r1 one idle cycle after r0's done
      setup(0, 0, 12, 32'h0000_05A3);
      setup(1, 1, 16, 32'h0000_BEEF);
      bus.req = 2'b11;
      @(negedge SCLK);
      check("tie_gnt0", bus.gnt, 2'b01);
      bus.req[0] = 1'b0;
      n = 0;
      while (!bus.done[0] && n < 500) begin
         @(negedge SCLK);
         n++;
      end
      check("tie_cs_gap", {bus.spi_cs1, bus.spi_cs0}, 2'b11);
      @(negedge SCLK);
      check("tie_gnt1", bus.gnt, 2'b10);
      bus.req[1] = 1'b0;
      wait_idle();
      // Held requests alternate r0, r1, r0, r1
      setup(0, 0, 3, 32'h5);
      setup(1, 1, 5, 32'h1B);
      setup(0, 0, 3, 32'h5);
      setup(1, 1, 5, 32'h1B);
      bus.req = 2'b11;
      g = 0;
      n = 0;
      while (g < 4 && n < 2000) begin
         @(negedge SCLK);
         n++;
         if (|bus.gnt) begin
            check("alt_gnt", bus.gnt, (g % 2) ? 2'b10 : 2'b01);
            g++;
         end
      end
      bus.req = '0;
      check("alt_count", g, 4);
      wait_idle();
      // Basic write with gnt latency and rdata hold
      setup(0, 0, 8, 32'hA5);
      bus.req[0] = 1'b1;
      @(negedge SCLK);
      check("gnt_latency", bus.gnt, 2'b01);
      bus.req[0] = 1'b0;
      wait_idle();
      repeat (3) @(negedge SCLK);
      check("rdata_hold", bus.rdata, 32'h3C);
      // Length edges
      for (int i = 0; i < 4; i++) begin
         setup(i % 2, i % 2, lens[i], $urandom);
         bus.req[i % 2] = 1'b1;
         wait_gnt(i % 2);
         wait_idle();
      end
      // Reset on the 5th rise aborts with no done; pointer returns to favour r0
      setup(0, 0, 20, 32'h0001_2345);
      bus.req[0] = 1'b1;
      wait_gnt(0);
      n = 0;
      while (s_rises < 5 && n < 500) begin
         @(negedge SCLK);
         n++;
      end
      check("rise5_wait", 64'(n < 500), 1);
      SRESETn = 1'b0;
      sbq.delete();
      #1;
      check("abort_lines", {bus.spi_cs1, bus.spi_cs0, bus.spi_clk, bus.spi_mosi}, 4'b1100);
      check("abort_rdata", bus.rdata, 0);
      repeat (2) @(negedge SCLK);
      check("abort_done", bus.done, 0);
      SRESETn = 1'b1;
      @(negedge SCLK);
      setup(0, 0, 6, 32'h2A);
      setup(1, 1, 7, 32'h55);
      bus.req = 2'b11;
      @(negedge SCLK);
      check("post_rst_gnt", bus.gnt, 2'b01);
      bus.req[0] = 1'b0;
      wait_gnt(1);
      wait_idle();
      // Fast-timing instance: 1 + 2*1*4 + 1 cycles of CS low
      bus2.len[5:0] = 6'd4;
      bus2.wdata[31:0] = 32'h9;
      bus2.req[0] = 1'b1;
      n = 0;
      c = 0;
      while (!bus2.done[0] && n < 200) begin
         @(negedge SCLK);
         n++;
         c += int'(!bus2.spi_cs0);
         if (bus2.gnt[0]) bus2.req[0] = 1'b0;
      end
      check("sweep_done", bus2.done, 2'b01);
      check("sweep_cs_low", c, 10);
      check("sweep_rdata", bus2.rdata, 32'hF);
      repeat (2) @(negedge SCLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2: SCLK cycles per spi_clk half-period (legal values 1..255).
REQ-002 The block SHALL have parameter CS_SETUP, default 2: SCLK cycles from CS assertion to the first spi_clk rise (legal values 1..15).
REQ-003 The block SHALL have parameter CS_HOLD, default 2: SCLK cycles from the last spi_clk fall to CS deassertion (legal values 1..15).
REQ-004 The block SHALL have ports as follows:
SCLK  in  1  single clock; all logic on its rising edge.
SRESETn  in  1  asynchronous, active-low reset.
req  in  2  per-requester transfer request; held until matching gnt.
sel  in  2  per-requester target slave (0 = spi_cs0, 1 = spi_cs1).
len  in  12  per-requester bit count, 6 bits each; requester r uses [6r+5:6r].
wdata  in  64  per-requester TX word, 32 bits each; requester r uses [32r+31:32r].
gnt  out  2  one-cycle pulse: the request has been captured.
done  out  2  one-cycle pulse: the transfer is complete.
rdata  out  32  RX word, right-aligned; valid in the done cycle and held until the next done.
spi_clk  out  1  SPI clock, mode 0, idle low.
spi_mosi  out  1  SPI serial out, MSB first.
spi_miso  in  1  SPI serial in (already muxed between slaves).
spi_cs0  out  1  slave 0 chip select, active low.
spi_cs1  out  1  slave 1 chip select, active low.

Function
REQ-005 The FSM SHALL have the states IDLE, SETUP, SHIFT and HOLD.
REQ-006 IDLE with any req bit high SHALL move to SETUP on the next cycle, capturing the winner's sel, len and wdata.
REQ-007 Arbitration SHALL be two-way round-robin: a lone requester wins; on simultaneous requests, the requester not granted last wins. The last-grant pointer SHALL reset to 1, so r0 wins the first tie.
REQ-008 gnt[winner] SHALL pulse in the first SETUP cycle. Any change or drop of req after gnt SHALL be ignored for the captured transfer.
REQ-009 The effective length SHALL be len when 1..32 and SHALL be 32 when len is 0 or greater than 32.
REQ-010 In SETUP, the selected CS SHALL be low, spi_clk low and spi_mosi equal to wdata[effective length - 1]. SETUP SHALL last CS_SETUP cycles, then move to SHIFT.
REQ-011 In SHIFT, each bit SHALL take 2*CLK_DIV cycles: spi_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-012 spi_miso SHALL be sampled into the shift register on the SCLK edge where spi_clk rises.
REQ-013 spi_mosi SHALL advance to the next bit on the SCLK edge where spi_clk falls.
REQ-014 After the high phase of the last bit, spi_clk SHALL return low and the FSM SHALL enter HOLD. The CS SHALL stay low for CS_HOLD cycles.
REQ-015 HOLD exit SHALL return to IDLE, deassert both CS, pulse done[owner] and update rdata[effective length - 1:0] with upper bits zero, all in the same cycle.
REQ-016 A transfer SHALL span CS_SETUP + 2*CLK_DIV*effective length + CS_HOLD cycles from the gnt cycle to the done cycle.
REQ-017 Both CS SHALL be high for at least 1 cycle between transfers; arbitration happens in that IDLE cycle.
REQ-018 Exactly one CS SHALL be low at any time outside IDLE, and never both.
REQ-019 spi_mosi SHALL be 0 in IDLE.
REQ-020 A requester SHALL NOT be granted again until its done has pulsed.

Reset
REQ-021 SRESETn low SHALL immediately, asynchronously, force: state = IDLE, spi_cs0 = spi_cs1 = 1, spi_clk = 0, spi_mosi = 0, gnt = done = 0, rdata = 0, last-grant pointer = 1.
REQ-022 Reset during SETUP, SHIFT or HOLD SHALL abort the transfer with no done pulse. Release SHALL be taken synchronously to SCLK.

Structure
REQ-023 Shared package spi_arb_pkg SHALL hold the FSM state enum (IDLE, SETUP, SHIFT, HOLD), the default values of CLK_DIV, CS_SETUP and CS_HOLD, and the constant MAX_LEN = 32.
REQ-024 The round-robin grant logic SHALL be a sub-module, spi_rr_arbiter2: inputs req[1:0] and advance; outputs a one-hot winner; it holds the last-grant pointer.
REQ-025 The shift/bit counters and the FSM SHALL live in spi_bus_arbiter.

Verification
REQ-026 Basic write, defaults: r0 requests sel=0, len=8, wdata=0xA5, with a slave echoing 0x3C -> gnt[0] 1 cycle after req; spi_cs0 low for 2+32+2 = 36 cycles; MOSI carries 1010_0101; done[0] in the cycle cs0 rises; rdata = 0x0000003C.
REQ-027 Tie: r0 and r1 request in the same cycle (r1 sel=1, len=16) -> r0 is served first, then r1 after 1 cycle with both CS high. With the r0 and r1 requests then held continuously, grants alternate r0, r1, r0, r1.
REQ-028 Length edges: len=1, len=32 and len=0 -> spi_clk rise counts of 1, 32 and 32; len=40 -> 32 rises.
REQ-029 Reset mid-SHIFT: assert SRESETn low on the 5th spi_clk rise -> both CS high and spi_clk low in the same cycle, no done; the next request after release is granted to r0.
REQ-030 Parameter sweep: CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, len=4 -> cs low for exactly 10 cycles. A CS-overlap assertion (spi_cs0 and spi_cs1 never both low) SHALL be checked throughout all scenarios.
